// File: rtl/mdu.sv
// rtl/mdu.sv - iterative MULT/MULTU/DIV/DIVU unit writing HI/LO
// Radix-2 shift-add multiply and restoring divide on magnitudes; signs fixed up at the end.
module mdu #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] porta,
  input  logic [WIDTH-1:0] portb,
  output logic             busy,
  output logic             done,
  output logic             divzero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_main;
  logic               neg_rem;
  logic               by_zero;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   raw_a;
  logic [2*WIDTH-1:0] acc;

  logic               sgn_a;
  logic               sgn_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_sub;
  logic               rem_ge;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;

  always_comb begin
    sgn_a   = porta[WIDTH-1] & ~op[0];
    sgn_b   = portb[WIDTH-1] & ~op[0];
    mag_a   = sgn_a ? -porta : porta;
    mag_b   = sgn_b ? -portb : portb;
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (b_reg[0] ? a_reg : '0)};
    // Partial remainder is always below the divisor, so the borrow bit alone decides the compare.
    rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, b_reg};
    rem_ge  = ~rem_sub[WIDTH];
    prod_s  = neg_main ? -acc : acc;
    quo_s   = neg_main ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_s   = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      by_zero  <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      raw_a    <= '0;
      acc      <= '0;
      hi       <= '0;
      lo       <= '0;
      divzero  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            is_div   <= op[1];
            neg_main <= sgn_a ^ sgn_b;
            neg_rem  <= sgn_a;
            by_zero  <= op[1] && (portb == '0);
            a_reg    <= mag_a;
            b_reg    <= mag_b;
            raw_a    <= porta;
            acc      <= op[1] ? {{WIDTH{1'b0}}, mag_a} : '0;
            cnt      <= '0;
            state    <= S_CALC;
          end else begin
            state <= S_IDLE;
          end
        end
        S_CALC: begin
          if (is_div) begin
            acc <= {(rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                    acc[WIDTH-2:0], rem_ge};
          end else begin
            acc   <= {mul_sum, acc[WIDTH-1:1]};
            b_reg <= b_reg >> 1;
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            cnt   <= '0;
            state <= S_FIX;
          end
        end
        S_FIX: begin
          if (by_zero) begin
            hi <= raw_a;
            lo <= '1;
          end else if (is_div) begin
            hi <= rem_s;
            lo <= quo_s;
          end else begin
            hi <= prod_s[2*WIDTH-1:WIDTH];
            lo <= prod_s[WIDTH-1:0];
          end
          divzero <= by_zero;
          state   <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_CALC) || (state == S_FIX);
  assign done = (state == S_DONE);

endmodule
